// File: rtl/bullcow_input_ctrl_pkg.sv
// bullcow_input_ctrl_pkg: shared types, sizes and the digit-uniqueness helper
package bullcow_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef digit_t [NUM_DIGITS-1:0] code_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT_RELEASE
    } in_state_t;

    function automatic logic digits_distinct(input code_t c);
        digits_distinct = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            for (int j = i + 1; j < NUM_DIGITS; j++)
                if (c[i] == c[j]) digits_distinct = 1'b0;
    endfunction

endpackage

// File: rtl/bullcow_input_ctrl_if.sv
// bullcow_input_ctrl_if: raw inputs from the board and the code handshake to the game FSM
interface bullcow_input_ctrl_if;
    import bullcow_pkg::*;

    logic  enter;
    logic  [15:0] SW;
    logic  accept_en;
    logic  enter_pulse;
    logic  [15:0] sw_sync;
    logic  code_valid;
    code_t code_out;
    logic  code_err;

    modport master (
        output enter, SW, accept_en,
        input  enter_pulse, sw_sync, code_valid, code_out, code_err
    );

    modport slave (
        input  enter, SW, accept_en,
        output enter_pulse, sw_sync, code_valid, code_out, code_err
    );

endinterface

// File: rtl/bullcow_input_ctrl_debouncer.sv
// btn_debouncer: synchronises and debounces a push-button, emits its debounced level and a rise strobe
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic db_level_o,
    output logic press_o
);

    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1_q, s2_q, db_q, db_prev_q, seen_q, armed_q;
    logic [CW-1:0] cnt_q;

    // Two-flop synchroniser; a button held through reset stays disarmed until it is seen released
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            seen_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            seen_q  <= 1'b1;
            armed_q <= armed_q | (seen_q & ~s1_q);
        end

    // Debounced level follows the synchronised input only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            db_prev_q <= db_q;
            if (s2_q == db_q)
                cnt_q <= '0;
            else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_q  <= s2_q;
                cnt_q <= '0;
            end else
                cnt_q <= cnt_q + 1'b1;
        end

    assign db_level_o = db_q;
    assign press_o    = armed_q & db_q & ~db_prev_q;

endmodule

// File: rtl/bullcow_input_ctrl.sv
// bullcow_input_ctrl: conditions enter/SW and hands checked codes to the game FSM (BULLCOW_DISTINCT_CHECK_EN enables digit check)
module bullcow_input_ctrl
    import bullcow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic clock,
    input logic reset,
    bullcow_input_ctrl_if.slave bus
);

    code_t     sw1_q, sw2_q, code_q, code_out_q;
    logic      pulse_q, valid_q, err_q;
    in_state_t state_q;
    logic      db_level, press, pass;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clock      (clock),
        .reset      (reset),
        .btn_i      (bus.enter),
        .db_level_o (db_level),
        .press_o    (press)
    );

    // Two-flop synchroniser for the switch bank
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            sw1_q <= '0;
            sw2_q <= '0;
        end else begin
            sw1_q <= bus.SW;
            sw2_q <= sw1_q;
        end

`ifdef BULLCOW_DISTINCT_CHECK_EN
    assign pass = digits_distinct(code_q);
`else
    assign pass = 1'b1;
`endif

    // Latch on an accepted press, judge the code for one cycle, then wait for the button to be released
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q    <= IDLE;
            code_q     <= '0;
            code_out_q <= '0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pulse_q <= press;
            valid_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (press && bus.accept_en) begin
                        code_q  <= sw2_q;
                        err_q   <= 1'b0;
                        state_q <= CHECK;
                    end
                CHECK: begin
                    valid_q <= pass;
                    err_q   <= ~pass;
                    if (pass) code_out_q <= code_q;
                    state_q <= WAIT_RELEASE;
                end
                WAIT_RELEASE:
                    if (!db_level) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end

    assign bus.enter_pulse = pulse_q;
    assign bus.sw_sync     = sw2_q;
    assign bus.code_valid  = valid_q;
    assign bus.code_out    = code_out_q;
    assign bus.code_err    = err_q;

endmodule

// File: tb/tb_bullcow_input_ctrl.sv
// tb_bullcow_input_ctrl: directed stimulus checked every cycle against a behavioural model plus literal expectations
module tb_bullcow_input_ctrl;
    import bullcow_pkg::*;

    localparam int N = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    bullcow_input_ctrl_if bus();

    bullcow_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_pulse = 0, n_valid = 0, pulse_cyc = 0, valid_cyc = 0;
    int p0, v0, c0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit distinct(input logic [15:0] c);
        bit [15:0] used = '0;
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = c[4*i +: 4];
            if (used[d]) return 1'b0;
            used[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    logic        m_s1, m_s2, m_db, m_dbq, m_armed, m_pulse, m_valid, m_err;
    logic [15:0] m_sw1, m_sw2, m_code, m_out;
    int          m_st, m_edges;
    bit          win[$];
    bit          m_press, m_pass, all_diff;

    // Behavioural model: debounced level flips once the last N synchronised samples all disagree with it
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            {m_s1, m_s2, m_db, m_dbq, m_armed, m_pulse, m_valid, m_err} = '0;
            {m_sw1, m_sw2, m_code, m_out} = '0;
            m_st = 0;
            m_edges = 0;
            win.delete();
        end else begin
            win.push_back(m_s2);
            if (win.size() > N) void'(win.pop_front());
            all_diff = (win.size() == N);
            foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
            m_press = m_armed & m_db & ~m_dbq;
            m_valid = 1'b0;
            if (m_st == 0) begin
                if (m_press && bus.accept_en) begin
                    m_code = m_sw2;
                    m_err = 1'b0;
                    m_st = 1;
                end
            end else if (m_st == 1) begin
`ifdef BULLCOW_DISTINCT_CHECK_EN
                m_pass = distinct(m_code);
`else
                m_pass = 1'b1;
`endif
                m_valid = m_pass;
                m_err = !m_pass;
                if (m_pass) m_out = m_code;
                m_st = 2;
            end else if (!m_db) m_st = 0;
            m_pulse = m_press;
            m_armed = m_armed | (m_edges > 0 && !m_s1);
            m_edges++;
            m_dbq = m_db;
            if (all_diff) m_db = ~m_db;
            m_s2 = m_s1;
            m_s1 = bus.enter;
            m_sw2 = m_sw1;
            m_sw1 = bus.SW;
        end
    end

    always @(posedge clock) cyc++;

    // Compare every output against the model away from the active edge
    always @(negedge clock) begin
        chk("enter_pulse", 32'(bus.enter_pulse), 32'(m_pulse));
        chk("sw_sync", 32'(bus.sw_sync), 32'(m_sw2));
        chk("code_valid", 32'(bus.code_valid), 32'(m_valid));
        chk("code_out", 32'(bus.code_out), 32'(m_out));
        chk("code_err", 32'(bus.code_err), 32'(m_err));
        if (bus.enter_pulse) begin n_pulse++; pulse_cyc = cyc; end
        if (bus.code_valid) begin n_valid++; valid_cyc = cyc; end
    end

    task automatic mark();
        p0 = n_pulse;
        v0 = n_valid;
        c0 = cyc;
    endtask

    task automatic press(input logic [15:0] sw, input int hold);
        bus.SW = sw;
        mark();
        bus.enter = 1'b1;
        repeat (hold) @(negedge clock);
        bus.enter = 1'b0;
        repeat (20) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.enter = 1'b0;
        bus.SW = 16'h0000;
        bus.accept_en = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_code_out", 32'(bus.code_out), 32'h0);
        chk("rst_code_valid", 32'(bus.code_valid), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        bus.accept_en = 1'b1;
        bus.SW = 16'h4321;
        mark();
        bus.enter = 1'b1;
        repeat (N - 2) @(negedge clock);
        bus.enter = 1'b0;
        repeat (20) @(negedge clock);
        chk("glitch_pulses", n_pulse - p0, 0);
        chk("glitch_valids", n_valid - v0, 0);

        press(16'h1234, 50);
        chk("valid_pulses", n_pulse - p0, 1);
        chk("valid_count", n_valid - v0, 1);
        chk("pulse_latency", pulse_cyc - c0, 11);
        chk("valid_latency", valid_cyc - c0, 12);
        chk("valid_code_out", 32'(bus.code_out), 32'h1234);
        chk("valid_code_err", 32'(bus.code_err), 0);

        press(16'h1123, 50);
`ifdef BULLCOW_DISTINCT_CHECK_EN
        chk("repeat_valids", n_valid - v0, 0);
        chk("repeat_code_err", 32'(bus.code_err), 1);
        chk("repeat_code_out", 32'(bus.code_out), 32'h1234);
`else
        chk("repeat_valids", n_valid - v0, 1);
        chk("repeat_code_err", 32'(bus.code_err), 0);
        chk("repeat_code_out", 32'(bus.code_out), 32'h1123);
`endif

        bus.accept_en = 1'b0;
        bus.SW = 16'h5678;
        mark();
        bus.enter = 1'b1;
        repeat (20) @(negedge clock);
        bus.accept_en = 1'b1;
        repeat (30) @(negedge clock);
        bus.enter = 1'b0;
        repeat (20) @(negedge clock);
        chk("disabled_pulses", n_pulse - p0, 1);
        chk("disabled_valids", n_valid - v0, 0);
`ifdef BULLCOW_DISTINCT_CHECK_EN
        chk("disabled_code_out", 32'(bus.code_out), 32'h1234);
`else
        chk("disabled_code_out", 32'(bus.code_out), 32'h1123);
`endif

        bus.SW = 16'h9ABC;
        mark();
        bus.enter = 1'b1;
        repeat (11) @(negedge clock);
        bus.SW = 16'h0000;
        repeat (39) @(negedge clock);
        bus.enter = 1'b0;
        repeat (20) @(negedge clock);
        chk("swchg_valids", n_valid - v0, 1);
        chk("swchg_code_out", 32'(bus.code_out), 32'h9ABC);
        chk("swchg_code_err", 32'(bus.code_err), 0);

        bus.SW = 16'h2345;
        bus.enter = 1'b1;
        repeat (11) @(negedge clock);
        chk("pre_rst_pulse", 32'(bus.enter_pulse), 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_enter_pulse", 32'(bus.enter_pulse), 0);
        chk("arst_sw_sync", 32'(bus.sw_sync), 0);
        chk("arst_code_valid", 32'(bus.code_valid), 0);
        chk("arst_code_out", 32'(bus.code_out), 0);
        chk("arst_code_err", 32'(bus.code_err), 0);
        @(negedge clock);
        reset = 1'b0;
        mark();
        repeat (40) @(negedge clock);
        chk("held_pulses", n_pulse - p0, 0);
        chk("held_valids", n_valid - v0, 0);
        bus.enter = 1'b0;
        repeat (20) @(negedge clock);
        press(16'h2345, 30);
        chk("repress_pulses", n_pulse - p0, 1);
        chk("repress_valids", n_valid - v0, 1);
        chk("repress_code_out", 32'(bus.code_out), 32'h2345);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
